expr_tx: RTL and testbench

EXPR_TX -- requirements
Module: expr_tx

---
 rtl/expr_pkg.sv | 34 +++
 rtl/expr_tx.sv | 127 ++++++++++++
 tb/tb_expr_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared constants, state enumeration and operand validation for expr_tx.
// The TERM state only exists when EXPR_TX_TERM_EN is defined.
package expr_pkg;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] PLUS = 8'h2B;
    localparam logic [7:0] STAR = 8'h2A;
    localparam logic [7:0] EQ   = 8'h3D;

    localparam int MAX_OPND = 8;

    typedef enum logic [1:0] {
        IDLE,
        DIG,
        OP
`ifdef EXPR_TX_TERM_EN
        ,
        TERM
`endif
    } state_e;

    // True when len is 1..MAX_OPND and every used operand nibble is a BCD digit.
    function automatic logic expr_ok(input logic [3:0] n, input logic [31:0] d);
        logic ok;
        ok = (n != 4'd0) && (n <= 4'(MAX_OPND));
        for (int k = 0; k < MAX_OPND; k++) begin
            if (k < int'(n) && d[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/expr_tx.sv
// Serialises a BCD operand/operator expression as ASCII, one character per cycle.
// Build option EXPR_TX_TERM_EN appends a trailing '=' and moves done onto it.
module expr_tx
    import expr_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    output logic [7:0]  out,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic [31:0] digits_q, digits_d;
    logic [6:0]  ops_q, ops_d;
    logic [2:0]  opnd_q, opnd_d;
    logic [2:0]  opr_q, opr_d;
    logic [7:0]  out_q, out_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        last_opnd;

    assign last_opnd = ({1'b0, opnd_q} == (len_q - 4'd1));

    // The FSM runs one cycle ahead of the registered character outputs, so it is
    // back in IDLE while the final character is still on the output.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        opnd_d   = opnd_q;
        opr_d    = opr_q;
        out_d    = 8'h00;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (expr_ok(len, digits)) begin
                        len_d    = len;
                        digits_d = digits;
                        ops_d    = ops;
                        opnd_d   = 3'd0;
                        opr_d    = 3'd0;
                        state_d  = DIG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIG: begin
                out_d   = ZERO + {4'h0, digits_q[{opnd_q, 2'b00} +: 4]};
                valid_d = 1'b1;
                if (last_opnd) begin
`ifdef EXPR_TX_TERM_EN
                    state_d = TERM;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = OP;
                end
            end
            OP: begin
                out_d   = ops_q[opr_q] ? STAR : PLUS;
                valid_d = 1'b1;
                opnd_d  = opnd_q + 3'd1;
                opr_d   = opr_q + 3'd1;
                state_d = DIG;
            end
`ifdef EXPR_TX_TERM_EN
            TERM: begin
                out_d   = EQ;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            len_q    <= 4'd0;
            digits_q <= 32'd0;
            ops_q    <= 7'd0;
            opnd_q   <= 3'd0;
            opr_q    <= 3'd0;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            opnd_q   <= opnd_d;
            opr_q    <= opr_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Self-checking bench for expr_tx: cycle-indexed expected-output schedule plus literal stream checks.
// Define EXPR_TX_TERM_EN for both bench and RTL to cover the '=' terminator build.
module tb_expr_tx;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  len;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic [7:0]  out;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        err;

    expr_tx dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .len       (len),
        .digits    (digits),
        .ops       (ops),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs indexed by the number of the edge after which they appear.
    logic [7:0] exp_out   [DEPTH];
    bit         exp_valid [DEPTH];
    bit         exp_done  [DEPTH];
    bit         exp_err   [DEPTH];
    int         cyc = 0;
    int         free_at = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_out[i] = 8'h00; exp_valid[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (clr) begin
            for (int i = cyc; i < DEPTH; i++) begin
                exp_out[i] = 8'h00; exp_valid[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
            end
            free_at = cyc + 1;
        end else if (start && cyc >= free_at) begin
            bit bad;
            int n;
            bad = (len == 4'd0) || (len > 4'd8);
            for (int k = 0; k < 8; k++)
                if (k < int'(len) && digits[4*k +: 4] > 4'd9) bad = 1;
            if (bad) begin
                if (cyc < DEPTH) exp_err[cyc] = 1;
            end else begin
                n = 0;
                for (int k = 0; k < int'(len); k++) begin
                    n++;
                    if (cyc + n < DEPTH) begin
                        exp_out[cyc+n] = 8'h30 + {4'h0, digits[4*k +: 4]};
                        exp_valid[cyc+n] = 1;
                    end
                    if (k < int'(len) - 1) begin
                        n++;
                        if (cyc + n < DEPTH) begin
                            exp_out[cyc+n] = ops[k] ? 8'h2A : 8'h2B;
                            exp_valid[cyc+n] = 1;
                        end
                    end
                end
`ifdef EXPR_TX_TERM_EN
                n++;
                if (cyc + n < DEPTH) begin
                    exp_out[cyc+n] = 8'h3D;
                    exp_valid[cyc+n] = 1;
                end
`endif
                if (cyc + n < DEPTH) exp_done[cyc+n] = 1;
                free_at = cyc + n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < DEPTH) begin
            vectors++;
            if (out !== exp_out[cyc] || out_valid !== exp_valid[cyc] || busy !== exp_valid[cyc] ||
                done !== exp_done[cyc] || err !== exp_err[cyc]) begin
                miscompares++;
                $display("FAIL cycle %0d: out=%h valid=%b busy=%b done=%b err=%b, expected out=%h valid=%b busy=%b done=%b err=%b",
                         cyc, out, out_valid, busy, done, err,
                         exp_out[cyc], exp_valid[cyc], exp_valid[cyc], exp_done[cyc], exp_err[cyc]);
            end
        end
    end

    byte got[$];
    int  done_cnt = 0;
    int  err_cnt = 0;
    byte last_done_char = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) got.push_back(out);
        if (done === 1'b1) begin
            done_cnt++;
            last_done_char = out;
        end
        if (err === 1'b1) err_cnt++;
    end

    function automatic string got_str();
        string s;
        s = "";
        foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
        return s;
    endfunction

    task automatic chk_str(input string name, input string act, input string exp_s);
        vectors++;
        if (act != exp_s) begin
            miscompares++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp_s);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_expr(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o);
        start = 1'b1; len = l; digits = d; ops = o;
        @(negedge clk);
        start = 1'b0;
    endtask

    int e0, d0;

    initial begin
        clr = 1'b1; start = 1'b0; len = 4'd0; digits = 32'd0; ops = 7'd0;
        tick(2);
        chk_int("reset_outputs", int'({out, out_valid, busy, done, err}), 0);
        clr = 1'b0;
        tick(2);

        // Basic stream
        got.delete(); d0 = done_cnt;
        start_expr(4'd3, 32'h00000931, 7'b0000010);
        tick(8);
`ifdef EXPR_TX_TERM_EN
        chk_str("basic_stream", got_str(), "1+3*9=");
        chk_int("basic_done_char", int'(last_done_char), 8'h3D);
`else
        chk_str("basic_stream", got_str(), "1+3*9");
        chk_int("basic_done_char", int'(last_done_char), 8'h39);
`endif
        chk_int("basic_done_count", done_cnt - d0, 1);

        // Illegal lengths
        got.delete(); e0 = err_cnt;
        start_expr(4'd0, 32'h00000001, 7'd0);
        tick(3);
        chk_int("len0_err", err_cnt - e0, 1);
        chk_int("len0_chars", got.size(), 0);
        e0 = err_cnt;
        start_expr(4'd9, 32'h11111111, 7'd0);
        tick(3);
        chk_int("len9_err", err_cnt - e0, 1);
        chk_int("len9_chars", got.size(), 0);

        // Bad BCD, then the same digits with only the legal operand used
        e0 = err_cnt;
        start_expr(4'd2, 32'h000000A1, 7'd0);
        tick(3);
        chk_int("badbcd_err", err_cnt - e0, 1);
        chk_int("badbcd_chars", got.size(), 0);
        e0 = err_cnt;
        start_expr(4'd1, 32'h000000A1, 7'd0);
        tick(4);
        chk_int("len1_err", err_cnt - e0, 0);
`ifdef EXPR_TX_TERM_EN
        chk_str("len1_stream", got_str(), "1=");
`else
        chk_str("len1_stream", got_str(), "1");
`endif

        // Start and input changes while streaming are ignored
        got.delete(); e0 = err_cnt;
        start_expr(4'd4, 32'h00004567, 7'b0000101);
        tick(2);
        start = 1'b1; digits = 32'h11111111; len = 4'd2; ops = 7'h7F;
        tick(2);
        start = 1'b0;
        tick(6);
`ifdef EXPR_TX_TERM_EN
        chk_str("midstream_ignore", got_str(), "7*6+5*4=");
`else
        chk_str("midstream_ignore", got_str(), "7*6+5*4");
`endif
        chk_int("midstream_err", err_cnt - e0, 0);

        // Abort an 8-operand stream after its second character
        got.delete(); d0 = done_cnt;
        start_expr(4'd8, 32'h87654321, 7'b1010101);
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(3);
        chk_str("abort_stream", got_str(), "1*");
        chk_int("abort_done", done_cnt - d0, 0);
        got.delete();
        start_expr(4'd2, 32'h00000055, 7'd0);
        tick(5);
`ifdef EXPR_TX_TERM_EN
        chk_str("after_abort", got_str(), "5+5=");
`else
        chk_str("after_abort", got_str(), "5+5");
`endif

        // clr wins over a simultaneous start
        got.delete(); e0 = err_cnt;
        clr = 1'b1; start = 1'b1; len = 4'd2; digits = 32'h00000012; ops = 7'd1;
        tick(1);
        clr = 1'b0; start = 1'b0;
        tick(4);
        chk_int("clr_priority_chars", got.size(), 0);
        chk_int("clr_priority_err", err_cnt - e0, 0);

        // Back-to-back single-digit expressions with start held high for 10 edges
        got.delete(); d0 = done_cnt;
        start = 1'b1; len = 4'd1; digits = 32'h00000008; ops = 7'd0;
        tick(10);
        start = 1'b0;
        tick(4);
`ifdef EXPR_TX_TERM_EN
        chk_str("back_to_back", got_str(), "8=8=8=8=");
        chk_int("back_to_back_done", done_cnt - d0, 4);
`else
        chk_str("back_to_back", got_str(), "88888");
        chk_int("back_to_back_done", done_cnt - d0, 5);
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
